// File: rtl/mux_32_if.sv
// Bus bundle for the 32:1 registered multiplexer: 32 data inputs, the
// select index and the registered result. The master side drives data and
// select and observes out; the slave side is the multiplexer itself.
`timescale 1ns/1ps
interface mux_32_if #(
    parameter int N = 32
);
    logic [N-1:0] in00;
    logic [N-1:0] in01;
    logic [N-1:0] in02;
    logic [N-1:0] in03;
    logic [N-1:0] in04;
    logic [N-1:0] in05;
    logic [N-1:0] in06;
    logic [N-1:0] in07;
    logic [N-1:0] in08;
    logic [N-1:0] in09;
    logic [N-1:0] in10;
    logic [N-1:0] in11;
    logic [N-1:0] in12;
    logic [N-1:0] in13;
    logic [N-1:0] in14;
    logic [N-1:0] in15;
    logic [N-1:0] in16;
    logic [N-1:0] in17;
    logic [N-1:0] in18;
    logic [N-1:0] in19;
    logic [N-1:0] in20;
    logic [N-1:0] in21;
    logic [N-1:0] in22;
    logic [N-1:0] in23;
    logic [N-1:0] in24;
    logic [N-1:0] in25;
    logic [N-1:0] in26;
    logic [N-1:0] in27;
    logic [N-1:0] in28;
    logic [N-1:0] in29;
    logic [N-1:0] in30;
    logic [N-1:0] in31;
    logic [4:0]   select;
    logic [N-1:0] out;

    modport master (
        output in00, in01, in02, in03, in04, in05, in06, in07,
               in08, in09, in10, in11, in12, in13, in14, in15,
               in16, in17, in18, in19, in20, in21, in22, in23,
               in24, in25, in26, in27, in28, in29, in30, in31,
               select,
        input  out
    );

    modport slave (
        input  in00, in01, in02, in03, in04, in05, in06, in07,
               in08, in09, in10, in11, in12, in13, in14, in15,
               in16, in17, in18, in19, in20, in21, in22, in23,
               in24, in25, in26, in27, in28, in29, in30, in31,
               select,
        output out
    );
endinterface

// File: rtl/mux_32.sv
// 32:1 multiplexer with a registered output. The selection is a balanced
// five-level tree of 2:1 muxes; level L is steered by select[L], level 0
// sits next to the inputs. A single N-bit register captures the tree output.
// The ternary operator is used throughout so an X on select shows up as X
// on the result in simulation rather than being silently resolved.
`timescale 1ns/1ps
module mux_32 #(
    parameter int N = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mux_32_if.slave  bus
);

    logic [N-1:0] lvl0 [32];
    logic [N-1:0] lvl1 [16];
    logic [N-1:0] lvl2 [8];
    logic [N-1:0] lvl3 [4];
    logic [N-1:0] lvl4 [2];
    logic [N-1:0] lvl5;
    logic [N-1:0] out_q;

    // Leaves of the tree, indexed by the input's number.
    assign lvl0[0]  = bus.in00;
    assign lvl0[1]  = bus.in01;
    assign lvl0[2]  = bus.in02;
    assign lvl0[3]  = bus.in03;
    assign lvl0[4]  = bus.in04;
    assign lvl0[5]  = bus.in05;
    assign lvl0[6]  = bus.in06;
    assign lvl0[7]  = bus.in07;
    assign lvl0[8]  = bus.in08;
    assign lvl0[9]  = bus.in09;
    assign lvl0[10] = bus.in10;
    assign lvl0[11] = bus.in11;
    assign lvl0[12] = bus.in12;
    assign lvl0[13] = bus.in13;
    assign lvl0[14] = bus.in14;
    assign lvl0[15] = bus.in15;
    assign lvl0[16] = bus.in16;
    assign lvl0[17] = bus.in17;
    assign lvl0[18] = bus.in18;
    assign lvl0[19] = bus.in19;
    assign lvl0[20] = bus.in20;
    assign lvl0[21] = bus.in21;
    assign lvl0[22] = bus.in22;
    assign lvl0[23] = bus.in23;
    assign lvl0[24] = bus.in24;
    assign lvl0[25] = bus.in25;
    assign lvl0[26] = bus.in26;
    assign lvl0[27] = bus.in27;
    assign lvl0[28] = bus.in28;
    assign lvl0[29] = bus.in29;
    assign lvl0[30] = bus.in30;
    assign lvl0[31] = bus.in31;

    // Level 0: 16 muxes pairing adjacent inputs, steered by select[0].
    for (genvar j = 0; j < 16; j++) begin : g_lvl0
        assign lvl1[j] = bus.select[0] ? lvl0[2*j+1] : lvl0[2*j];
    end

    // Level 1: 8 muxes, steered by select[1].
    for (genvar j = 0; j < 8; j++) begin : g_lvl1
        assign lvl2[j] = bus.select[1] ? lvl1[2*j+1] : lvl1[2*j];
    end

    // Level 2: 4 muxes, steered by select[2].
    for (genvar j = 0; j < 4; j++) begin : g_lvl2
        assign lvl3[j] = bus.select[2] ? lvl2[2*j+1] : lvl2[2*j];
    end

    // Level 3: 2 muxes, steered by select[3].
    for (genvar j = 0; j < 2; j++) begin : g_lvl3
        assign lvl4[j] = bus.select[3] ? lvl3[2*j+1] : lvl3[2*j];
    end

    // Level 4: final mux choosing the in00..in15 or in16..in31 half.
    assign lvl5 = bus.select[4] ? lvl4[1] : lvl4[0];

    // Output register; the async clear wins over any capture in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= lvl5;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_mux_32.sv
`timescale 1ns/1ps
module tb_mux_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din [32];
    logic [4:0]  sel;

    int n_checks = 0;
    int n_fail   = 0;

    mux_32_if #(.N(32)) bif ();
    mux_32_if #(.N(8))  bif8 ();

    mux_32 #(.N(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
    mux_32 #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bif8.slave));

    always #5 clk = ~clk;

    assign bif.select  = sel;
    assign bif8.select = sel;

    assign bif.in00 = din[0];   assign bif8.in00 = din[0][7:0];
    assign bif.in01 = din[1];   assign bif8.in01 = din[1][7:0];
    assign bif.in02 = din[2];   assign bif8.in02 = din[2][7:0];
    assign bif.in03 = din[3];   assign bif8.in03 = din[3][7:0];
    assign bif.in04 = din[4];   assign bif8.in04 = din[4][7:0];
    assign bif.in05 = din[5];   assign bif8.in05 = din[5][7:0];
    assign bif.in06 = din[6];   assign bif8.in06 = din[6][7:0];
    assign bif.in07 = din[7];   assign bif8.in07 = din[7][7:0];
    assign bif.in08 = din[8];   assign bif8.in08 = din[8][7:0];
    assign bif.in09 = din[9];   assign bif8.in09 = din[9][7:0];
    assign bif.in10 = din[10];  assign bif8.in10 = din[10][7:0];
    assign bif.in11 = din[11];  assign bif8.in11 = din[11][7:0];
    assign bif.in12 = din[12];  assign bif8.in12 = din[12][7:0];
    assign bif.in13 = din[13];  assign bif8.in13 = din[13][7:0];
    assign bif.in14 = din[14];  assign bif8.in14 = din[14][7:0];
    assign bif.in15 = din[15];  assign bif8.in15 = din[15][7:0];
    assign bif.in16 = din[16];  assign bif8.in16 = din[16][7:0];
    assign bif.in17 = din[17];  assign bif8.in17 = din[17][7:0];
    assign bif.in18 = din[18];  assign bif8.in18 = din[18][7:0];
    assign bif.in19 = din[19];  assign bif8.in19 = din[19][7:0];
    assign bif.in20 = din[20];  assign bif8.in20 = din[20][7:0];
    assign bif.in21 = din[21];  assign bif8.in21 = din[21][7:0];
    assign bif.in22 = din[22];  assign bif8.in22 = din[22][7:0];
    assign bif.in23 = din[23];  assign bif8.in23 = din[23][7:0];
    assign bif.in24 = din[24];  assign bif8.in24 = din[24][7:0];
    assign bif.in25 = din[25];  assign bif8.in25 = din[25][7:0];
    assign bif.in26 = din[26];  assign bif8.in26 = din[26][7:0];
    assign bif.in27 = din[27];  assign bif8.in27 = din[27][7:0];
    assign bif.in28 = din[28];  assign bif8.in28 = din[28][7:0];
    assign bif.in29 = din[29];  assign bif8.in29 = din[29][7:0];
    assign bif.in30 = din[30];  assign bif8.in30 = din[30][7:0];
    assign bif.in31 = din[31];  assign bif8.in31 = din[31][7:0];

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_both(input string name, input logic [31:0] exp);
        check({name, "_n32"}, bif.out, exp);
        check({name, "_n8"}, {24'h0, bif8.out}, {24'h0, exp[7:0]});
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_identity();
        for (int k = 0; k < 32; k++) din[k] = 32'(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        logic [31:0] prev;

        // Reset held low with clock running: out stays 0.
        load_identity();
        sel = 5'd5;
        #1;
        check_both("reset_initial", 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_both("reset_hold", 32'h0);
        end
        #2;
        rst_n = 1'b1;
        #1;
        check_both("reset_release_before_edge", 32'h0);
        tick();
        check_both("reset_release", 32'd5);

        // Table-driven sweep with in_k = k, including the half boundary.
        vecs[0] = '{5'd0,  32'd0};
        vecs[1] = '{5'd1,  32'd1};
        vecs[2] = '{5'd2,  32'd2};
        vecs[3] = '{5'd3,  32'd3};
        vecs[4] = '{5'd15, 32'd15};
        vecs[5] = '{5'd16, 32'd16};
        vecs[6] = '{5'd31, 32'd31};
        vecs[7] = '{5'd10, 32'd10};
        vecs[8] = '{5'd21, 32'd21};
        vecs[9] = '{5'd0,  32'd0};
        for (int i = 0; i < 10; i++) begin
            sel = vecs[i].sel;
            tick();
            check_both("table_sweep", vecs[i].exp);
        end

        // Full range in consecutive cycles; out lags select by one edge.
        prev = 32'd0;
        for (int s = 0; s < 32; s++) begin
            sel = 5'(s);
            #1;
            check_both("full_range_lag", prev);
            tick();
            check_both("full_range", 32'(s));
            prev = 32'(s);
        end

        // Bit independence on a single hot input.
        for (int k = 0; k < 32; k++) din[k] = 32'h0;
        din[7] = 32'hA5A5_5A5A;
        sel = 5'd7;
        tick();
        check_both("bit_pattern_sel7", 32'hA5A5_5A5A);
        sel = 5'd8;
        tick();
        check_both("bit_pattern_sel8", 32'h0);

        // Async reset between edges, then recovery.
        load_identity();
        sel = 5'd20;
        tick();
        check_both("async_pre", 32'd20);
        #2;
        rst_n = 1'b0;
        #1;
        check_both("async_clear", 32'h0);
        tick();
        check_both("async_hold_low", 32'h0);
        rst_n = 1'b1;
        #1;
        check_both("async_release_before_edge", 32'h0);
        tick();
        check_both("async_recover", 32'd20);

        // Input change between edges is invisible until the edge.
        sel = 5'd12;
        tick();
        check_both("hold_pre", 32'd12);
        #2;
        din[12] = 32'hDEAD_BEEF;
        #1;
        check_both("hold_between_edges", 32'd12);
        sel = 5'd13;
        #1;
        sel = 5'd12;
        #1;
        check_both("hold_sel_glitch", 32'd12);
        tick();
        check_both("hold_update", 32'hDEAD_BEEF);

        // Random data and select against a simple indexed model.
        for (int r = 0; r < 300; r++) begin
            for (int k = 0; k < 32; k++) din[k] = $urandom;
            sel = 5'($urandom_range(0, 31));
            exp = din[sel];
            tick();
            check_both("random", exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_32.md
Name: mux_32

Overview:
- 32:1 multiplexer, parameterised data width N, with a registered output.
- Selects one of 32 N-bit inputs (in00..in31) using a 5-bit select.
- Captures the selected value on the rising clock edge.
- Generic datapath building block, e.g. register-file read port or ALU result select. Exercised stand-alone with in_k = k.

Parameters:
- N, 32, width in bits of every data input and of the output; legal range N >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears the output register.
- in00..in31  input  N each  data inputs; inK is selected when select == K (K = 0..31, two-digit decimal suffix).
- select  input  5  unsigned index of the input to forward.
- out  output  N  registered selected data.

Behaviour:
- Reset: rst_n low forces out = 0 (all N bits) immediately, independent of clk. Out holds 0 while rst_n stays low.
- Reset release: first rising clk edge with rst_n high loads the mux result.
- Reset mid-operation: the async clear overrides any pending capture. Data selected in the cycle of reset is discarded.
- Normal operation: each rising clk edge with rst_n high sets out <= in[select], evaluated from the values present just before the edge.
- Latency: exactly 1 clock from select/data change to out.
- Throughput: one new selection every cycle, no handshake, no enable.
- Hold: out changes only on a clk edge or on reset assertion. Input or select changes between edges have no effect until the next edge.
- Decode: the 5-bit select covers all 32 inputs, so there are no out-of-range codes.
  - Select 0 maps to in00; select 31 maps to in31.
  - Decode is exact binary: select bit 4 chooses the in00..in15 versus in16..in31 half, and so on down to bit 0.
- Structure: combinational 32:1 selection as a balanced 5-level tree of 2:1 muxes (16+8+4+2+1). Level L is steered by select[L], level 0 nearest the inputs. A single output register of N flops follows the tree.
- Width: no truncation or extension; out bit i comes only from bit i of the selected input.
- X handling: an X/Z on select propagates as X in simulation. No X-masking logic.
- No other state: no internal counters or flags.

Test Plan:
- Reset: hold rst_n = 0 with inputs in_k = k, select = 5, clk toggling -> out == 0 throughout. Release rst_n -> out == 5 after the next rising edge.
- Sequential sweep: in_k = k (32-bit), select = 0,1,2,3, each held 10 ns over one rising edge -> out == 0,1,2,3 respectively, each appearing one edge after select changes.
- Full range: select 0..31 in consecutive cycles -> out equals 0..31, lagging select by exactly 1 cycle.
  - Includes boundaries select = 16 (out 16) and select = 31 (out 31).
- Bit independence: in07 = 32'hA5A5_5A5A, all others 0, select = 7 -> out == 32'hA5A5_5A5A. Set select = 8 -> out == 0 next edge.
- Async reset mid-stream: select = 20, out == 20; assert rst_n low between clock edges -> out == 0 before the next edge. Deassert -> out == 20 after the next edge.
- Hold and parameter check: change in12 between edges while select = 12 -> out updates only at the edge. Repeat the sweep with N = 8 -> out == k[7:0].
